// File: rtl/wash_pkg.sv
// Shared encodings for the washing-machine front end and wash FSM.
package wash_pkg;

  typedef enum logic [1:0] {
    SEL_NONE   = 2'b00,
    SEL_BASIC  = 2'b01,
    SEL_NORMAL = 2'b10,
    SEL_HEAVY  = 2'b11
  } wash_sel_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_ARMED  = 2'b01,
    S_LOCKED = 2'b10
  } wash_state_e;

  // Heavy wins over normal, normal over basic.
  function automatic wash_sel_e encode_sel(input logic basic, input logic normal,
                                           input logic heavy);
    if (heavy) begin
      return SEL_HEAVY;
    end else if (normal) begin
      return SEL_NORMAL;
    end else if (basic) begin
      return SEL_BASIC;
    end
    return SEL_NONE;
  endfunction

endpackage

// File: rtl/input_debouncer.sv
// Two-flop synchronizer followed by a stability counter that gates level changes.
module input_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic level
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  logic            sync1_q, sync2_q;
  logic            level_q, level_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Counter clears on any agreeing cycle; the level flips on the cycle the count would hit the limit.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync2_q != level_q) begin
      if (cnt_q == CntLast) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CntOne;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;

endmodule

// File: rtl/wash_input_conditioner.sv
// Conditions raw coin/select/lid switches for the wash FSM: coin pulse, locked selection, step tick.
// Optional COIN_LOCKOUT_EN suppresses coin pulses while the selection is locked.
module wash_input_conditioner
  import wash_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned STEP_DIV        = 50000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       coin_raw,
  input  logic       basic_raw,
  input  logic       normal_raw,
  input  logic       heavy_raw,
  input  logic       lid_raw,
  input  logic       run_done,
  output logic       coin_pulse,
  output logic [1:0] wash_sel,
  output logic       lid_closed,
  output logic       sel_locked,
  output logic       step_tick
);

  localparam int unsigned StepW = $clog2(STEP_DIV + 1);
  localparam logic [StepW-1:0] StepLast = StepW'(STEP_DIV - 1);
  localparam logic [StepW-1:0] StepOne = StepW'(1);

  logic [4:0] raw_vec, lvl_vec;
  logic       coin_lvl, basic_lvl, normal_lvl, heavy_lvl, lid_lvl;

  assign raw_vec = {lid_raw, heavy_raw, normal_raw, basic_raw, coin_raw};
  assign {lid_lvl, heavy_lvl, normal_lvl, basic_lvl, coin_lvl} = lvl_vec;

  for (genvar i = 0; i < 5; i++) begin : g_db
    input_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clock(clock),
      .reset(reset),
      .raw  (raw_vec[i]),
      .level(lvl_vec[i])
    );
  end

  wash_state_e      state_q, state_d;
  wash_sel_e        sel_q, sel_d, sel_live, sel_out;
  logic             locked;
  logic             coin_lvl_q, coin_rise;
  logic [StepW-1:0] step_q, step_d;
  logic             tick_q, tick_d;

  assign sel_live = encode_sel(basic_lvl, normal_lvl, heavy_lvl);
  assign locked   = (state_q == S_LOCKED);

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    sel_out = SEL_NONE;
    unique case (state_q)
      S_IDLE: begin
        if (sel_live != SEL_NONE) state_d = S_ARMED;
      end
      S_ARMED: begin
        sel_out = sel_live;
        if (lid_lvl && (sel_live != SEL_NONE)) begin
          state_d = S_LOCKED;
          sel_d   = sel_live;
        end else if (sel_live == SEL_NONE) begin
          state_d = S_IDLE;
        end
      end
      S_LOCKED: begin
        sel_out = sel_q;
        if (run_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Counter sits at zero outside the lock, so entry and exit both start it from zero.
  always_comb begin
    step_d = step_q;
    tick_d = 1'b0;
    if (!locked || run_done) begin
      step_d = '0;
    end else if (lid_lvl) begin
      if (step_q == StepLast) begin
        step_d = '0;
        tick_d = 1'b1;
      end else begin
        step_d = step_q + StepOne;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      sel_q      <= SEL_NONE;
      coin_lvl_q <= 1'b0;
      step_q     <= '0;
      tick_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      coin_lvl_q <= coin_lvl;
      step_q     <= step_d;
      tick_q     <= tick_d;
    end
  end

  // Rising edge of the debounced level, high in the cycle right after the level flips.
  assign coin_rise = coin_lvl & ~coin_lvl_q;

`ifdef COIN_LOCKOUT_EN
  assign coin_pulse = coin_rise & ~locked;
`else
  assign coin_pulse = coin_rise;
`endif

  assign wash_sel   = sel_out;
  assign lid_closed = lid_lvl;
  assign sel_locked = locked;
  assign step_tick  = tick_q;

endmodule
